// File: rtl/css_rvjtag_dtm_hs.sv
// RISC-V JTAG Debug Transport Module: IEEE 1149.1 TAP with IDCODE, DTMCS and
// DMI data registers. DMI accesses leave as a valid/ready request and come back
// as a single-cycle response. Everything runs in the tck domain.
module css_rvjtag_dtm_hs #(
  parameter int                  AWIDTH       = 7,
  parameter int                  IR_WIDTH     = 5,
  parameter logic [IR_WIDTH-1:0] IDCODE_IR    = 5'h01,
  parameter logic [IR_WIDTH-1:0] DTMCS_IR     = 5'h10,
  parameter logic [IR_WIDTH-1:0] DMI_IR       = 5'h11,
  parameter logic [31:0]         IDCODE_VALUE = 32'h0000_0001,
  parameter logic [2:0]          IDLE_HINT    = 3'd1
) (
  input  logic              tck,
  input  logic              trst,
  input  logic              tms,
  input  logic              tdi,
  output logic              tdo,
  output logic              tdo_en,
  output logic              dmi_req_valid,
  input  logic              dmi_req_ready,
  output logic [AWIDTH-1:0] dmi_req_addr,
  output logic [31:0]       dmi_req_data,
  output logic [1:0]        dmi_req_op,
  input  logic              dmi_rsp_valid,
  input  logic [31:0]       dmi_rsp_data,
  input  logic              dmi_rsp_err,
  output logic              dmi_reset,
  output logic              dmi_hard_reset
);

  localparam int DW = AWIDTH + 34;

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_e;

  typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_DTMCS, DR_DMI} dr_sel_e;

  tap_state_e          state;
  dr_sel_e             dr_sel;
  logic [IR_WIDTH-1:0] ir;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [DW-1:0]       dr_sr;
  logic [DW-1:0]       dr_shifted;
  logic [31:0]         dtmcs_capture;
  logic [1:0]          op_status;
  logic [1:0]          sticky;
  logic                pending;
  logic [31:0]         rsp_data_q;
  logic [AWIDTH-1:0]   last_addr;

  // TAP controller: standard 16-state walk driven by tms.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      state <= TLR;
    end else begin
      case (state)
        TLR:     state <= tms ? TLR    : RTI;
        RTI:     state <= tms ? SEL_DR : RTI;
        SEL_DR:  state <= tms ? SEL_IR : CAP_DR;
        CAP_DR:  state <= tms ? EX1_DR : SH_DR;
        SH_DR:   state <= tms ? EX1_DR : SH_DR;
        EX1_DR:  state <= tms ? UPD_DR : PAU_DR;
        PAU_DR:  state <= tms ? EX2_DR : PAU_DR;
        EX2_DR:  state <= tms ? UPD_DR : SH_DR;
        UPD_DR:  state <= tms ? SEL_DR : RTI;
        SEL_IR:  state <= tms ? TLR    : CAP_IR;
        CAP_IR:  state <= tms ? EX1_IR : SH_IR;
        SH_IR:   state <= tms ? EX1_IR : SH_IR;
        EX1_IR:  state <= tms ? UPD_IR : PAU_IR;
        PAU_IR:  state <= tms ? EX2_IR : PAU_IR;
        EX2_IR:  state <= tms ? UPD_IR : SH_IR;
        UPD_IR:  state <= tms ? SEL_DR : RTI;
        default: state <= TLR;
      endcase
    end
  end

  // Decode the active IR into a data-register select and build the shift/capture words.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    dr_sel = DR_BYPASS;
    if (ir == IDCODE_IR)     dr_sel = DR_IDCODE;
    else if (ir == DTMCS_IR) dr_sel = DR_DTMCS;
    else if (ir == DMI_IR)   dr_sel = DR_DMI;

    case (dr_sel)
      DR_DMI:              dr_shifted = {tdi, dr_sr[DW-1:1]};
      DR_IDCODE, DR_DTMCS: dr_shifted = {{(DW-32){1'b0}}, tdi, dr_sr[31:1]};
      default:             dr_shifted = {{(DW-1){1'b0}}, tdi};
    endcase

    op_status     = (sticky != 2'd0) ? sticky : (pending ? 2'd3 : 2'd0);
    dtmcs_capture = {14'b0, 2'b0, 1'b0, IDLE_HINT, sticky, 6'(AWIDTH), 4'd1};
  end

  // IR shift register: capture the 01 pattern, shift LSB-first.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir_sr <= '0;
    end else if (state == CAP_IR) begin
      ir_sr <= {{(IR_WIDTH-1){1'b0}}, 1'b1};
    end else if (state == SH_IR) begin
      ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
    end
  end

  // Active IR updates on the falling edge; all-zero maps to BYPASS.
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      ir <= IDCODE_IR;
    end else if (state == TLR) begin
      ir <= IDCODE_IR;
    end else if (state == UPD_IR) begin
      ir <= (ir_sr == '0) ? '1 : ir_sr;
    end
  end

  // Data shift register shared by all DRs, sized for the longest (DMI).
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      dr_sr <= '0;
    end else if (state == CAP_DR) begin
      case (dr_sel)
        DR_IDCODE: dr_sr <= {{(DW-32){1'b0}}, IDCODE_VALUE};
        DR_DTMCS:  dr_sr <= {{(DW-32){1'b0}}, dtmcs_capture};
        DR_DMI:    dr_sr <= {last_addr, rsp_data_q, op_status};
        default:   dr_sr <= '0;
      endcase
    end else if (state == SH_DR) begin
      dr_sr <= dr_shifted;
    end
  end

  // Output enable follows the shift states, aligned with tdo on the falling edge.
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) tdo_en <= 1'b0;
    else       tdo_en <= (state == SH_DR) || (state == SH_IR);
  end

  // Serial output launched on the falling edge so the host samples it on the rising edge.
  // NOTE: tdo is deliberately unreset; it is only meaningful while tdo_en is high.
  always_ff @(negedge tck) begin
    tdo <= (state == SH_IR) ? ir_sr[0] : dr_sr[0];
  end

  // DMI request/response tracking, sticky status and DTMCS reset strobes.
  // Later assignments take priority: capture/update over response, DTMCS resets last.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      dmi_req_valid  <= 1'b0;
      dmi_req_addr   <= '0;
      dmi_req_data   <= '0;
      dmi_req_op     <= '0;
      dmi_reset      <= 1'b0;
      dmi_hard_reset <= 1'b0;
      sticky         <= '0;
      pending        <= 1'b0;
      rsp_data_q     <= '0;
      last_addr      <= '0;
    end else begin
      dmi_reset      <= 1'b0;
      dmi_hard_reset <= 1'b0;

      if (dmi_req_valid && dmi_req_ready) dmi_req_valid <= 1'b0;

      if (dmi_rsp_valid && pending) begin
        pending    <= 1'b0;
        rsp_data_q <= dmi_rsp_data;
        if (dmi_rsp_err && sticky == 2'd0) sticky <= 2'd2;
      end

      if (state == TLR) sticky <= 2'd0;

      if (state == CAP_DR && dr_sel == DR_DMI && pending && sticky == 2'd0) sticky <= 2'd3;

      if (state == UPD_DR && dr_sel == DR_DMI && sticky == 2'd0) begin
        if (pending) begin
          sticky <= 2'd3;
        end else if (dr_sr[1:0] == 2'd1 || dr_sr[1:0] == 2'd2) begin
          dmi_req_valid <= 1'b1;
          dmi_req_addr  <= dr_sr[DW-1:34];
          dmi_req_data  <= dr_sr[33:2];
          dmi_req_op    <= dr_sr[1:0];
          pending       <= 1'b1;
          last_addr     <= dr_sr[DW-1:34];
        end
      end

      if (state == UPD_DR && dr_sel == DR_DTMCS) begin
        if (dr_sr[16]) begin
          dmi_reset <= 1'b1;
          sticky    <= 2'd0;
        end
        if (dr_sr[17]) begin
          dmi_hard_reset <= 1'b1;
          sticky         <= 2'd0;
          pending        <= 1'b0;
          dmi_req_valid  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_css_rvjtag_dtm_hs.sv
// Directed bench for css_rvjtag_dtm_hs: drives JTAG scans from the host side
// and plays the debug module on the DMI request/response interface.
module tb_css_rvjtag_dtm_hs;

  logic        tck = 1'b0;
  logic        trst, tms, tdi;
  logic        tdo, tdo_en;
  logic        dmi_req_valid, dmi_req_ready;
  logic [6:0]  dmi_req_addr;
  logic [31:0] dmi_req_data;
  logic [1:0]  dmi_req_op;
  logic        dmi_rsp_valid;
  logic [31:0] dmi_rsp_data;
  logic        dmi_rsp_err;
  logic        dmi_reset, dmi_hard_reset;

  int total = 0;
  int bad   = 0;
  logic        en_seen;
  logic [63:0] dout;
  logic [4:0]  icap;
  logic        dummy;

  css_rvjtag_dtm_hs dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
    .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
    .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_data(dmi_rsp_data), .dmi_rsp_err(dmi_rsp_err),
    .dmi_reset(dmi_reset), .dmi_hard_reset(dmi_hard_reset)
  );

  always #5 tck = ~tck;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One tck cycle: drive tms/tdi, sample tdo before the rising edge, settle after the falling edge.
  task automatic tick(input logic m, input logic d, output logic o);
    tms = m;
    tdi = d;
    o   = tdo;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  task automatic idle(input int n);
    logic b;
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, b);
  endtask

  task automatic reset_tap();
    logic b;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, b);
    tick(1'b0, 1'b0, b);
  endtask

  // From Run-Test/Idle, shift an IR value and return to Run-Test/Idle.
  task automatic ir_scan(input logic [4:0] v, output logic [4:0] cap);
    logic b;
    tick(1'b1, 1'b0, b);
    tick(1'b1, 1'b0, b);
    tick(1'b0, 1'b0, b);
    tick(1'b0, 1'b0, b);
    for (int i = 0; i < 5; i++) begin
      tick(i == 4, v[i], b);
      cap[i] = b;
    end
    tick(1'b1, 1'b0, b);
    tick(1'b0, 1'b0, b);
  endtask

  // From Run-Test/Idle, shift n DR bits and return to Run-Test/Idle via Update-DR.
  task automatic dr_scan(input logic [63:0] din, input int n, output logic [63:0] res);
    logic b;
    res = '0;
    tick(1'b1, 1'b0, b);
    tick(1'b0, 1'b0, b);
    tick(1'b0, 1'b0, b);
    en_seen = tdo_en;
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, din[i], b);
      res[i] = b;
    end
    tick(1'b1, 1'b0, b);
    tick(1'b0, 1'b0, b);
  endtask

  function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d,
                                           input logic [1:0] op);
    return {23'b0, a, d, op};
  endfunction

  task automatic respond(input logic [31:0] d, input logic err);
    logic b;
    dmi_rsp_valid = 1'b1;
    dmi_rsp_data  = d;
    dmi_rsp_err   = err;
    tick(1'b0, 1'b0, b);
    dmi_rsp_valid = 1'b0;
    dmi_rsp_data  = '0;
    dmi_rsp_err   = 1'b0;
  endtask

  initial begin
    trst = 1'b0; tms = 1'b1; tdi = 1'b0;
    dmi_req_ready = 1'b0; dmi_rsp_valid = 1'b0; dmi_rsp_data = '0; dmi_rsp_err = 1'b0;
    repeat (2) @(negedge tck);
    #1;
    check("reset_outputs",
          {dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_reset, dmi_hard_reset, tdo_en},
          64'd0);
    trst = 1'b1;
    @(negedge tck);
    #1;
    reset_tap();

    // IDCODE
    ir_scan(5'h01, icap);
    check("ir_capture", icap, 5'b00001);
    dr_scan(64'd0, 32, dout);
    check("idcode", dout, 64'h0000_0001);
    check("tdo_en_shift", en_seen, 1'b1);
    check("tdo_en_idle", tdo_en, 1'b0);

    // BYPASS from all-zero IR: one-cycle delay with a captured 0
    ir_scan(5'h00, icap);
    dr_scan(64'hA5, 8, dout);
    check("bypass", dout, 64'h4A);

    // DTMCS
    ir_scan(5'h10, icap);
    dr_scan(64'd0, 32, dout);
    check("dtmcs_reset", dout, 64'h0000_1071);

    // DMI write with ready stalled three cycles
    ir_scan(5'h11, icap);
    dr_scan(dmi_word(7'h10, 32'hDEADBEEF, 2'd2), 41, dout);
    check("dmi_first_capture", dout, 64'd0);
    check("write_req", {dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op},
          {1'b1, 7'h10, 32'hDEADBEEF, 2'd2});
    idle(3);
    check("write_req_held", {dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op},
          {1'b1, 7'h10, 32'hDEADBEEF, 2'd2});
    dmi_req_ready = 1'b1;
    tick(1'b0, 1'b0, dummy);
    dmi_req_ready = 1'b0;
    check("write_req_drop", dmi_req_valid, 1'b0);
    respond(32'h0, 1'b0);
    dr_scan(dmi_word(7'h00, 32'h0, 2'd0), 41, dout);
    check("write_done_capture", dout, dmi_word(7'h10, 32'h0, 2'd0));

    // DMI read with a late response; a capture while pending reports busy
    dr_scan(dmi_word(7'h05, 32'h0, 2'd1), 41, dout);
    check("read_req", {dmi_req_valid, dmi_req_addr, dmi_req_op}, {1'b1, 7'h05, 2'd1});
    dmi_req_ready = 1'b1;
    tick(1'b0, 1'b0, dummy);
    dmi_req_ready = 1'b0;
    dr_scan(dmi_word(7'h00, 32'h0, 2'd0), 41, dout);
    check("busy_capture", dout, dmi_word(7'h05, 32'h0, 2'd3));
    respond(32'h1234_5678, 1'b0);
    ir_scan(5'h10, icap);
    dr_scan(64'd0, 32, dout);
    check("dtmcs_busy", dout, 64'h0000_1C71);
    ir_scan(5'h11, icap);
    dr_scan(dmi_word(7'h22, 32'h1111_2222, 2'd2), 41, dout);
    check("sticky_busy_capture", dout, dmi_word(7'h05, 32'h1234_5678, 2'd3));
    check("sticky_req_ignored", dmi_req_valid, 1'b0);
    ir_scan(5'h10, icap);
    dr_scan(64'h1_0000, 32, dout);
    check("dmireset_pulse", {dmi_reset, dmi_hard_reset}, 2'b10);
    tick(1'b0, 1'b0, dummy);
    check("dmireset_pulse_end", dmi_reset, 1'b0);
    dr_scan(64'd0, 32, dout);
    check("dtmcs_cleared", dout, 64'h0000_1071);

    // DMI read that fails: sticky failed status survives later captures
    ir_scan(5'h11, icap);
    dr_scan(dmi_word(7'h07, 32'h0, 2'd1), 41, dout);
    check("err_read_capture", dout, dmi_word(7'h05, 32'h1234_5678, 2'd0));
    dmi_req_ready = 1'b1;
    tick(1'b0, 1'b0, dummy);
    dmi_req_ready = 1'b0;
    respond(32'hCAFE_F00D, 1'b1);
    dr_scan(dmi_word(7'h00, 32'h0, 2'd0), 41, dout);
    check("failed_capture", dout, dmi_word(7'h07, 32'hCAFE_F00D, 2'd2));
    dr_scan(dmi_word(7'h00, 32'h0, 2'd0), 41, dout);
    check("failed_sticky", dout, dmi_word(7'h07, 32'hCAFE_F00D, 2'd2));
    ir_scan(5'h10, icap);
    dr_scan(64'h1_0000, 32, dout);
    check("dtmcs_failed", dout, 64'h0000_1871);

    // Outstanding request aborted by dmihardreset; the stale response is dropped
    ir_scan(5'h11, icap);
    dr_scan(dmi_word(7'h33, 32'h0, 2'd1), 41, dout);
    check("hard_read_capture", dout, dmi_word(7'h07, 32'hCAFE_F00D, 2'd0));
    ir_scan(5'h10, icap);
    check("hard_req_pending", dmi_req_valid, 1'b1);
    dr_scan(64'h2_0000, 32, dout);
    check("hard_dtmcs_capture", dout, 64'h0000_1071);
    check("hard_reset_pulse", {dmi_hard_reset, dmi_reset, dmi_req_valid}, 3'b100);
    respond(32'h5555_5555, 1'b1);
    check("hard_reset_pulse_end", dmi_hard_reset, 1'b0);
    ir_scan(5'h11, icap);
    dr_scan(dmi_word(7'h00, 32'h0, 2'd0), 41, dout);
    check("stale_rsp_ignored", dout, dmi_word(7'h33, 32'hCAFE_F00D, 2'd0));

    // trst in the middle of a transaction clears everything at once
    dr_scan(dmi_word(7'h01, 32'hABCD_0123, 2'd2), 41, dout);
    check("pre_trst_req", dmi_req_valid, 1'b1);
    trst = 1'b0;
    #1;
    check("trst_clear", {dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op}, 64'd0);
    @(negedge tck);
    #1;
    trst = 1'b1;
    reset_tap();
    ir_scan(5'h11, icap);
    dr_scan(dmi_word(7'h00, 32'h0, 2'd0), 41, dout);
    check("trst_dmi_capture", dout, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
